// File: rtl/memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_if
//  Description : Bundle of the MEM-stage signals: control/data arriving from
//                EX/MEM, the data-cache request/response pair, and the
//                registered MEM/WB outputs.
//                The master modport drives the inputs; the slave modport is
//                the MEM stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_if;
    // Pipeline control
    logic        flush_i;
    logic        stall_i;
    logic        mem_write_en_i;
    logic        reg_write_en_i;
    logic        forward_en_i;
    logic        data_cache_valid_i;
    logic [1:0]  wb_sel_i;
    logic [4:0]  reg_write_dst_i;

    // Data
    logic [31:0] cout_i;
    logic [31:0] result_i;
    logic [31:0] read_data_2_i;
    logic [31:0] forward_data_i;
    logic [31:0] data_from_cache_i;

    // MEM/WB register outputs
    logic        reg_write_en_o;
    logic [1:0]  wb_sel_o;
    logic [4:0]  reg_write_dst_o;
    logic [31:0] result_o;
    logic [31:0] cout_o;
    logic [31:0] read_data_o;

    // Cache request and stall request (combinational)
    logic        wr_to_cache_o;
    logic [31:0] data_to_cache_o;
    logic [31:0] addr_to_cache_o;
    logic        stall_o;

    modport master (
        output flush_i, stall_i, mem_write_en_i, reg_write_en_i, forward_en_i,
               data_cache_valid_i, wb_sel_i, reg_write_dst_i, cout_i, result_i,
               read_data_2_i, forward_data_i, data_from_cache_i,
        input  reg_write_en_o, wb_sel_o, reg_write_dst_o, result_o, cout_o,
               read_data_o, wr_to_cache_o, data_to_cache_o, addr_to_cache_o,
               stall_o
    );

    modport slave (
        input  flush_i, stall_i, mem_write_en_i, reg_write_en_i, forward_en_i,
               data_cache_valid_i, wb_sel_i, reg_write_dst_i, cout_i, result_i,
               read_data_2_i, forward_data_i, data_from_cache_i,
        output reg_write_en_o, wb_sel_o, reg_write_dst_o, result_o, cout_o,
               read_data_o, wr_to_cache_o, data_to_cache_o, addr_to_cache_o,
               stall_o
    );
endinterface
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module      : memory
//  Description : MEM pipeline stage. Issues the data-cache request
//                combinationally from the EX/MEM values and captures the
//                MEM/WB register (control, ALU result, cout, load data).
//  Ports       : clk_i  - rising-edge clock
//                rst_i  - synchronous active-high reset
//                bus    - memory_if.slave (pipeline inputs, cache request,
//                         MEM/WB outputs, stall_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory (
    input  logic     clk_i,
    input  logic     rst_i,
    memory_if.slave  bus
);

    // A flushed or stalled instruction must not touch the cache.
    logic        w_block_req;
    // The register freezes on an external stall or while the cache is busy.
    logic        w_hold;
    logic [31:0] w_store_data;

    logic        r_reg_write_en;
    logic [1:0]  r_wb_sel;
    logic [4:0]  r_reg_write_dst;
    logic [31:0] r_result;
    logic [31:0] r_cout;
    logic [31:0] r_read_data;

    assign w_block_req  = bus.flush_i | bus.stall_i;
    assign w_hold       = bus.stall_i | ~bus.data_cache_valid_i;
    assign w_store_data = bus.forward_en_i ? bus.forward_data_i : bus.read_data_2_i;

    // Cache request is purely a function of the current inputs; reset does
    // not gate it.
    always_comb begin
        bus.wr_to_cache_o   = 1'b0;
        bus.data_to_cache_o = 32'd0;
        bus.addr_to_cache_o = 32'd0;
        if (!w_block_req) begin
            bus.wr_to_cache_o   = bus.mem_write_en_i;
            bus.data_to_cache_o = w_store_data;
            bus.addr_to_cache_o = bus.result_i;
        end
    end

    assign bus.stall_o = ~bus.data_cache_valid_i;

    // MEM/WB register: reset, then flush (bubble, wins over stall), then
    // hold, then load.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_reg_write_en  <= 1'b0;
            r_wb_sel        <= 2'd0;
            r_reg_write_dst <= 5'd0;
            r_result        <= 32'd0;
            r_cout          <= 32'd0;
            r_read_data     <= 32'd0;
        end else if (!w_hold) begin
            r_reg_write_en  <= bus.reg_write_en_i;
            r_wb_sel        <= bus.wb_sel_i;
            r_reg_write_dst <= bus.reg_write_dst_i;
            r_result        <= bus.result_i;
            r_cout          <= bus.cout_i;
            r_read_data     <= bus.data_from_cache_i;
        end
    end

    assign bus.reg_write_en_o  = r_reg_write_en;
    assign bus.wb_sel_o        = r_wb_sel;
    assign bus.reg_write_dst_o = r_reg_write_dst;
    assign bus.result_o        = r_result;
    assign bus.cout_o          = r_cout;
    assign bus.read_data_o     = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory
//  Description : Scoreboard bench for the MEM stage. The driver applies
//                directed vectors one cycle at a time and queues the
//                hand-computed expectations tagged with the cycle in which
//                they must be visible; a monitor on the falling edge pops
//                and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory;

    logic clk;
    logic rst;
    int   cyc;

    memory_if bus ();

    memory dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks;
    int   n_pass;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0: return {31'd0, bus.reg_write_en_o};
            1: return {30'd0, bus.wb_sel_o};
            2: return {27'd0, bus.reg_write_dst_o};
            3: return bus.result_o;
            4: return bus.cout_o;
            5: return bus.read_data_o;
            6: return {31'd0, bus.wr_to_cache_o};
            7: return bus.data_to_cache_o;
            8: return bus.addr_to_cache_o;
            default: return {31'd0, bus.stall_o};
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "reg_write_en_o";
            1: return "wb_sel_o";
            2: return "reg_write_dst_o";
            3: return "result_o";
            4: return "cout_o";
            5: return "read_data_o";
            6: return "wr_to_cache_o";
            7: return "data_to_cache_o";
            8: return "addr_to_cache_o";
            default: return "stall_o";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [31:0] a;
                a = actual(q[i].sel);
                n_checks++;
                if (a === q[i].exp && q[i].due == cyc)
                    n_pass++;
                else
                    $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h",
                             sel_name(q[i].sel), cyc, a, q[i].exp);
                q.delete(i);
            end
        end
    end

    task automatic push(input int due, input int sel, input logic [31:0] v);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    // Cache request and stall_o: visible in the current cycle.
    task automatic exp_cache(input logic wr, input logic [31:0] d,
                             input logic [31:0] a, input logic st);
        push(cyc, 6, {31'd0, wr});
        push(cyc, 7, d);
        push(cyc, 8, a);
        push(cyc, 9, {31'd0, st});
    endtask

    // MEM/WB register: visible after the next rising edge.
    task automatic exp_reg(input logic rwe, input logic [1:0] wb,
                           input logic [4:0] dst, input logic [31:0] res,
                           input logic [31:0] co, input logic [31:0] rd);
        push(cyc + 1, 0, {31'd0, rwe});
        push(cyc + 1, 1, {30'd0, wb});
        push(cyc + 1, 2, {27'd0, dst});
        push(cyc + 1, 3, res);
        push(cyc + 1, 4, co);
        push(cyc + 1, 5, rd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic rwe, input logic [1:0] wb,
                          input logic [4:0] dst, input logic [31:0] res,
                          input logic [31:0] co, input logic [31:0] rd);
        bus.reg_write_en_i    = rwe;
        bus.wb_sel_i          = wb;
        bus.reg_write_dst_i   = dst;
        bus.result_i          = res;
        bus.cout_i            = co;
        bus.data_from_cache_i = rd;
    endtask

    task automatic set_st(input logic we, input logic fe,
                          input logic [31:0] rd2, input logic [31:0] fwd);
        bus.mem_write_en_i = we;
        bus.forward_en_i   = fe;
        bus.read_data_2_i  = rd2;
        bus.forward_data_i = fwd;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst                    = 1'b1;
        bus.flush_i            = 1'b0;
        bus.stall_i            = 1'b0;
        bus.data_cache_valid_i = 1'b1;
        set_wb(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        set_st(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset: registers clear, cache request still follows inputs.
        step();
        rst = 1'b1;
        set_wb(1'b1, 2'd3, 5'd4, 32'h0000_0100, 32'h1, 32'h2);
        set_st(1'b1, 1'b0, 32'h77, 32'h0);
        exp_cache(1'b1, 32'h77, 32'h0000_0100, 1'b0);
        exp_reg(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Pass-through and load data.
        step();
        rst = 1'b0;
        set_wb(1'b1, 2'd2, 5'h1F, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);
        set_st(1'b0, 1'b0, 32'h0, 32'h0);
        exp_cache(1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        exp_reg(1'b1, 2'd2, 5'h1F, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);

        // Store from read_data_2.
        step();
        set_wb(1'b0, 2'd1, 5'd3, 32'h0000_1000, 32'hA, 32'h1111_1111);
        set_st(1'b1, 1'b0, 32'h55AA_55AA, 32'h0BAD_F00D);
        exp_cache(1'b1, 32'h55AA_55AA, 32'h0000_1000, 1'b0);
        exp_reg(1'b0, 2'd1, 5'd3, 32'h0000_1000, 32'hA, 32'h1111_1111);

        // Store with forwarded data.
        step();
        set_wb(1'b1, 2'd1, 5'd5, 32'h0000_2000, 32'hA, 32'h1111_1111);
        set_st(1'b1, 1'b1, 32'h55AA_55AA, 32'h0BAD_F00D);
        exp_cache(1'b1, 32'h0BAD_F00D, 32'h0000_2000, 1'b0);
        exp_reg(1'b1, 2'd1, 5'd5, 32'h0000_2000, 32'hA, 32'h1111_1111);

        // Flush during a store.
        step();
        bus.flush_i = 1'b1;
        set_wb(1'b1, 2'd2, 5'd6, 32'h0000_3000, 32'hB, 32'h2222_2222);
        exp_cache(1'b0, 32'h0, 32'h0, 1'b0);
        exp_reg(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Known value before the stall window.
        step();
        bus.flush_i = 1'b0;
        set_wb(1'b1, 2'd3, 5'h0A, 32'h44, 32'h55, 32'h66);
        set_st(1'b0, 1'b0, 32'h99, 32'h0);
        exp_cache(1'b0, 32'h99, 32'h44, 1'b0);
        exp_reg(1'b1, 2'd3, 5'h0A, 32'h44, 32'h55, 32'h66);

        // External stall for 20 cycles with changing inputs.
        for (int i = 0; i < 20; i++) begin
            step();
            bus.stall_i = 1'b1;
            set_wb(i[0], i[1:0], i[4:0], 32'h1000_0000 + i, 32'h2000_0000 + i,
                   32'h3000_0000 + i);
            set_st(~i[0], i[1], 32'h4000_0000 + i, 32'h5000_0000 + i);
            exp_cache(1'b0, 32'h0, 32'h0, 1'b0);
            exp_reg(1'b1, 2'd3, 5'h0A, 32'h44, 32'h55, 32'h66);
        end

        // Cache not ready: stall_o raised, register holds, request passes.
        step();
        bus.stall_i            = 1'b0;
        bus.data_cache_valid_i = 1'b0;
        set_wb(1'b0, 2'd1, 5'd2, 32'h34, 32'h56, 32'h78);
        set_st(1'b1, 1'b0, 32'h12, 32'h0);
        exp_cache(1'b1, 32'h12, 32'h34, 1'b1);
        exp_reg(1'b1, 2'd3, 5'h0A, 32'h44, 32'h55, 32'h66);

        // Load a fresh value.
        step();
        bus.data_cache_valid_i = 1'b1;
        set_wb(1'b1, 2'd2, 5'd7, 32'hAB, 32'hCD, 32'hEF);
        set_st(1'b0, 1'b0, 32'h0, 32'h0);
        exp_cache(1'b0, 32'h0, 32'hAB, 1'b0);
        exp_reg(1'b1, 2'd2, 5'd7, 32'hAB, 32'hCD, 32'hEF);

        // Flush together with stall and cache busy: flush wins.
        step();
        bus.flush_i            = 1'b1;
        bus.stall_i            = 1'b1;
        bus.data_cache_valid_i = 1'b0;
        set_st(1'b1, 1'b0, 32'hF0, 32'h0);
        exp_cache(1'b0, 32'h0, 32'h0, 1'b1);
        exp_reg(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Resume loading.
        step();
        bus.flush_i            = 1'b0;
        bus.stall_i            = 1'b0;
        bus.data_cache_valid_i = 1'b1;
        set_wb(1'b1, 2'd1, 5'd9, 32'h111, 32'h222, 32'h333);
        set_st(1'b0, 1'b0, 32'h0, 32'h0);
        exp_cache(1'b0, 32'h0, 32'h111, 1'b0);
        exp_reg(1'b1, 2'd1, 5'd9, 32'h111, 32'h222, 32'h333);

        // Mid-stream reset.
        step();
        rst = 1'b1;
        set_wb(1'b1, 2'd2, 5'h1F, 32'h999, 32'h888, 32'h777);
        set_st(1'b1, 1'b0, 32'h5, 32'h0);
        exp_cache(1'b1, 32'h5, 32'h999, 1'b0);
        exp_reg(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

        // Release reset: loading resumes at the next edge.
        step();
        rst = 1'b0;
        exp_cache(1'b1, 32'h5, 32'h999, 1'b0);
        exp_reg(1'b1, 2'd2, 5'h1F, 32'h999, 32'h888, 32'h777);

        repeat (3) @(negedge clk);
        #1;
        while (q.size() > 0) begin
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never checked, expected 0x%08h",
                     sel_name(q[0].sel), q[0].due, q[0].exp);
            void'(q.pop_front());
        end

        // Settled state after reset release with unchanged inputs.
        n_checks++;
        if (bus.result_o === 32'h999)
            n_pass++;
        else
            $display("FAIL result_o final: got 0x%08h expected 0x%08h", bus.result_o, 32'h999);
        n_checks++;
        if (bus.cout_o === 32'h888)
            n_pass++;
        else
            $display("FAIL cout_o final: got 0x%08h expected 0x%08h", bus.cout_o, 32'h888);
        n_checks++;
        if (bus.read_data_o === 32'h777)
            n_pass++;
        else
            $display("FAIL read_data_o final: got 0x%08h expected 0x%08h", bus.read_data_o, 32'h777);
        n_checks++;
        if (bus.addr_to_cache_o === 32'h999)
            n_pass++;
        else
            $display("FAIL addr_to_cache_o final: got 0x%08h expected 0x%08h", bus.addr_to_cache_o, 32'h999);
        n_checks++;
        if (bus.data_to_cache_o === 32'h5)
            n_pass++;
        else
            $display("FAIL data_to_cache_o final: got 0x%08h expected 0x%08h", bus.data_to_cache_o, 32'h5);
        n_checks++;
        if (bus.wr_to_cache_o === 1'b1)
            n_pass++;
        else
            $display("FAIL wr_to_cache_o final: got %b expected 1", bus.wr_to_cache_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i, input, 1, synchronous, active-high reset.
REQ-003 SHALL have flush_i, input, 1: flush; clears the MEM/WB register and suppresses any cache access.
REQ-004 SHALL have stall_i, input, 1: stall; holds the MEM/WB register and suppresses any cache access.
REQ-005 SHALL have the following control inputs:
- mem_write_en_i, input, 1: store request.
- reg_write_en_i, input, 1: register-write control, passed through.
- forward_en_i, input, 1: selects forward_data_i as store data.
- data_cache_valid_i, input, 1: D-cache response valid.
REQ-006 SHALL have wb_sel_i, input, 2, and reg_write_dst_i, input, 5; both passed through.
REQ-007 SHALL have the following 32-bit data inputs:
- cout_i, input, 32: passed through.
- result_i, input, 32: ALU result; also the memory address.
- read_data_2_i, input, 32: store data.
- forward_data_i, input, 32: forwarded store data.
- data_from_cache_i, input, 32: load data.
REQ-008 SHALL have the following registered outputs:
- reg_write_en_o, output, 1.
- wb_sel_o, output, 2.
- reg_write_dst_o, output, 5.
- result_o, output, 32.
- cout_o, output, 32.
- read_data_o, output, 32.
REQ-009 SHALL have the following combinational outputs:
- wr_to_cache_o, output, 1.
- data_to_cache_o, output, 32.
- addr_to_cache_o, output, 32.
- stall_o, output, 1.

Function
REQ-010 addr_to_cache_o SHALL equal result_i combinationally.
REQ-011 data_to_cache_o SHALL equal forward_data_i when forward_en_i=1, else read_data_2_i.
REQ-012 wr_to_cache_o SHALL equal mem_write_en_i combinationally.
REQ-013 When flush_i=1 or stall_i=1, wr_to_cache_o, data_to_cache_o and addr_to_cache_o SHALL all be 0 in the same cycle.
REQ-014 stall_o SHALL equal NOT data_cache_valid_i, combinationally.
REQ-015 The MEM/WB register SHALL hold reg_write_en, wb_sel, reg_write_dst, result, cout and read_data.
REQ-016 Each MEM/WB output SHALL show its input, with read_data_o taken from data_from_cache_i, exactly 1 cycle after capture.
REQ-017 MEM/WB register update priority per edge SHALL be: rst_i, then flush_i, then hold, then load.
- rst_i: all fields 0.
- flush_i: all fields 0 (bubble; reg_write_en_o=0).
- stall_i=1 or stall_o=1: all fields hold their value.
- Otherwise: load all fields.
REQ-018 Simultaneous flush_i and stall_i SHALL flush.
REQ-019 No other state SHALL exist; cache request outputs SHALL depend only on current inputs.

Reset
REQ-020 With rst_i=1 at an edge, all registered outputs SHALL be 0 after that edge.
REQ-021 Cache request outputs SHALL follow REQ-010..013 regardless of rst_i.
REQ-022 Deasserting rst_i SHALL resume normal loading on the next edge.

Verification
REQ-023 Pass-through:
- Stimulus: reg_write_en_i=1, wb_sel_i=2, reg_write_dst_i=0x1F, result_i=0xDEADBEEF, cout_i=0x12345678, no stall/flush.
- Response: identical values on the _o ports one edge later and thereafter while held.
REQ-024 Load: data_from_cache_i=0xCAFEF00D, data_cache_valid_i=1 -> read_data_o=0xCAFEF00D after one edge.
REQ-025 Store:
- mem_write_en_i=1, read_data_2_i=0x55AA55AA, result_i=0x00001000 -> same cycle wr_to_cache_o=1, data_to_cache_o=0x55AA55AA, addr_to_cache_o=0x00001000.
- forward_en_i=1, forward_data_i=0x0BADF00D -> data_to_cache_o=0x0BADF00D.
REQ-026 Flush: flush_i=1 during a store -> cache request outputs all 0 immediately; after the edge, reg_write_en_o=0 and all registered outputs are 0.
REQ-027 Stall:
- stall_i=1 held for 20 cycles with changing inputs -> cache request outputs stay 0 and registered outputs keep their pre-stall values.
- data_cache_valid_i=0 -> stall_o=1 and the MEM/WB register holds.
REQ-028 Reset: rst_i=1 for one edge mid-stream -> all registered outputs 0 after that edge.
